swu_rd_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single read port (B side) of the sliding-window buffer RAM between NREQ read

---
 rtl/swu_rd_arbiter_if.sv | 28 ++
 rtl/swu_rd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_swu_rd_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/swu_rd_arbiter_if.sv
// Read-port bundle between the sliding-window read requesters, the arbiter and RAM port B.
// slave: arbiter view. master: requesters + RAM view.
interface swu_rd_arbiter_if #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_data;
    logic [NREQ-1:0]            rsp_ready;
    logic                       ram_en;
    logic                       ram_enq;
    logic [ADDR_WIDTH-1:0]      ram_addr;
    logic [DATA_WIDTH-1:0]      ram_do;

    modport slave (
        input  req_valid, req_addr, rsp_ready, ram_do,
        output req_ready, rsp_valid, rsp_data, ram_en, ram_enq, ram_addr
    );

    modport master (
        output req_valid, req_addr, rsp_ready, ram_do,
        input  req_ready, rsp_valid, rsp_data, ram_en, ram_enq, ram_addr
    );
endinterface

// File: rtl/swu_rd_arbiter.sv
// Round-robin arbiter for the sliding-window buffer RAM read port (B side).
// Grants one requester per cycle, drives the 2-cycle RAM read pipeline and returns read
// words in issue order through a tagged response FIFO. Issue is credit-limited so the
// FIFO can never overflow.
// Optional: define SWU_RDARB_STATS_EN to add grant_cnt / conflict_cnt statistic outputs.
module swu_rd_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    swu_rd_arbiter_if.slave       bus
`ifdef SWU_RDARB_STATS_EN
    ,
    output logic [NREQ*32-1:0]    grant_cnt,
    output logic [31:0]           conflict_cnt
`endif
);

    localparam int unsigned TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]      ptr_q;
    logic [TAG_W-1:0]      grant_idx;
    logic [TAG_W-1:0]      cand;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  issue_ok;
    logic [1:0]            inflight;

    logic                  s1_v_q, s2_v_q;
    logic [TAG_W-1:0]      s1_tag_q, s2_tag_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [TAG_W-1:0]      fifo_tag_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  push, pop, empty, full;

    // Credit: reads already issued but not yet in the FIFO still reserve an entry.
    assign inflight = {1'b0, s1_v_q} + {1'b0, s2_v_q};
    assign issue_ok = (32'(count_q) + 32'(inflight)) < FIFO_DEPTH;

    // Round-robin search starting after the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = TAG_W'((32'(ptr_q) + k) % NREQ);
            if (!grant_any && issue_ok && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot ready and address mux; address holds its last value when idle.
    always_comb begin
        bus.req_ready = '0;
        grant_addr    = addr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_any && grant_idx == TAG_W'(i)) begin
                bus.req_ready[i] = 1'b1;
                grant_addr       = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        bus.ram_en   = grant_any;
        bus.ram_addr = grant_addr;
        bus.ram_enq  = s1_v_q;
    end

    // Arbiter pointer, held address and the two read-pipeline tag stages.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q    <= TAG_W'(NREQ - 1);
            addr_q   <= '0;
            s1_v_q   <= 1'b0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_tag_q <= '0;
        end else begin
            if (grant_any) begin
                ptr_q  <= grant_idx;
                addr_q <= grant_addr;
            end
            s1_v_q   <= grant_any;
            s1_tag_q <= grant_idx;
            s2_v_q   <= s1_v_q;
            s2_tag_q <= s1_tag_q;
        end
    end

    assign push  = s2_v_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop   = !empty && (|(bus.rsp_valid & bus.rsp_ready));

    // FIFO head drives the response; only the head's tag sees rsp_valid.
    always_comb begin
        bus.rsp_valid = '0;
        if (!empty) begin
            bus.rsp_valid[fifo_tag_q[rd_ptr_q]] = 1'b1;
        end
        bus.rsp_data = fifo_data_q[rd_ptr_q];
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.ram_do;
                fifo_tag_q[wr_ptr_q]  <= s2_tag_q;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    no_push_when_full: assert property (@(posedge aclk) disable iff (areset) !(push && full));
`endif

`ifdef SWU_RDARB_STATS_EN
    logic [31:0]  grant_cnt_q [NREQ];
    logic [31:0]  conflict_cnt_q;
    int unsigned  nvalid;
    logic         multi_req;

    // Cycles with two or more simultaneous requests count as conflicts.
    always_comb begin
        nvalid = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            nvalid = nvalid + 32'(bus.req_valid[i]);
        end
        multi_req = (nvalid >= 2);
    end

    // Saturating statistic counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            conflict_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant_any && grant_idx == TAG_W'(i) && grant_cnt_q[i] != '1) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (multi_req && conflict_cnt_q != '1) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    // Flatten the per-requester counters onto the output bus.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt[i*32 +: 32] = grant_cnt_q[i];
        end
        conflict_cnt = conflict_cnt_q;
    end
`endif

endmodule

// File: tb/tb_swu_rd_arbiter.sv
// Self-checking bench for swu_rd_arbiter: scoreboard of expected {tag,data} pushed on
// every observed grant and popped on every observed response handshake.
module tb_swu_rd_arbiter;

    localparam int unsigned NREQ       = 2;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct {
        int              tag;
        logic [7:0]      data;
    } exp_t;

    logic aclk;
    logic areset;
    logic [7:0] ram_r1;
    logic [7:0] ram_do_r;

    int n_tests;
    int n_fail;
    int phase_grants;
    exp_t sb[$];
    int   gseq[$];

    swu_rd_arbiter_if #(
        .NREQ       (NREQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) bus ();

`ifdef SWU_RDARB_STATS_EN
    logic [NREQ*32-1:0] grant_cnt;
    logic [31:0]        conflict_cnt;
`endif

    swu_rd_arbiter #(
        .NREQ       (NREQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .bus          (bus)
`ifdef SWU_RDARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hC3;
    endfunction

    // RAM port B model: address registered on ram_en, output register on ram_enq.
    always @(posedge aclk) begin
        if (bus.ram_en) ram_r1 <= mem_word(bus.ram_addr);
        if (bus.ram_enq) ram_do_r <= ram_r1;
    end
    assign bus.ram_do = ram_do_r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return bus.req_addr[i*8 +: 8];
    endfunction

    // Observe the handshakes that the coming rising edge will commit, then advance a cycle.
    task automatic tick();
        logic [1:0] g;
        logic [1:0] p;
        exp_t e;
        #1;
        if (!areset) begin
            g = bus.req_valid & bus.req_ready;
            check_eq("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            check_eq("ram_en", 32'(bus.ram_en), 32'(|g));
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    sb.push_back('{i, mem_word(addr_of(i))});
                    gseq.push_back(i);
                    phase_grants++;
                    check_eq("ram_addr", 32'(bus.ram_addr), 32'(addr_of(i)));
                end
            end
            check_eq("rsp_onehot0", 32'($onehot0(bus.rsp_valid)), 32'd1);
            p = bus.rsp_valid & bus.rsp_ready;
            if (p != 2'b00) begin
                check_eq("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("rsp_tag", (p == 2'b10) ? 32'd1 : 32'd0, 32'(e.tag));
                    check_eq("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                end
            end
        end
        @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        areset  = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = '0;
        repeat (3) @(negedge aclk);
        #1;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_ram_en", 32'(bus.ram_en), 32'd0);
        check_eq("rst_ram_enq", 32'(bus.ram_enq), 32'd0);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(negedge aclk);
        areset = 1'b0;

        // Both requesters busy, responses always accepted: strict alternation from 0.
        bus.rsp_ready = 2'b11;
        gseq.delete();
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = 2'b11;
            bus.req_addr  = {8'(2 * c + 1), 8'(2 * c)};
            tick();
        end
        check_eq("t1_grants", 32'(gseq.size()), 32'd10);
        for (int k = 0; k < gseq.size(); k++) begin
            check_eq("t1_order", 32'(gseq[k]), 32'(k % 2));
        end
`ifdef SWU_RDARB_STATS_EN
        check_eq("stat_grant0", grant_cnt[31:0], 32'd5);
        check_eq("stat_grant1", grant_cnt[63:32], 32'd5);
        check_eq("stat_conflict", conflict_cnt, 32'd10);
`endif
        bus.req_valid = 2'b00;
        repeat (6) tick();
        check_eq("t1_drained", 32'(sb.size()), 32'd0);

        // Single requester 1, consecutive addresses, exact 3-cycle response latency.
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            bus.req_addr = {8'(5 + c), 8'd0};
            #1;
            check_eq("t2_ram_addr", 32'(bus.ram_addr), 32'(5 + c));
            check_eq("t2_rsp_idle", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        bus.req_valid = 2'b00;
        #1;
        check_eq("t2_latency", 32'(bus.rsp_valid), 32'b10);
        check_eq("t2_data", 32'(bus.rsp_data), 32'(mem_word(8'd5)));
        repeat (4) tick();
        check_eq("t2_drained", 32'(sb.size()), 32'd0);

        // Credit limit: no responses accepted, exactly FIFO_DEPTH grants.
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        bus.req_addr  = {8'd0, 8'd77};
        phase_grants  = 0;
        repeat (10) tick();
        check_eq("t3_grants", 32'(phase_grants), 32'(FIFO_DEPTH));
        #1;
        check_eq("t3_stalled", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 2'b01;
        phase_grants  = 0;
        tick();
        bus.rsp_ready = 2'b00;
        repeat (8) tick();
        check_eq("t3_regrant", 32'(phase_grants), 32'd1);
        check_eq("t3_stalled2", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        repeat (8) tick();
        check_eq("t3_drained", 32'(sb.size()), 32'd0);

        // Head-of-line blocking: tag 0 at head, only requester 1 ready.
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b01;
        bus.req_addr  = {8'd40, 8'd30};
        tick();
        bus.req_valid = 2'b10;
        tick();
        bus.req_addr  = {8'd41, 8'd30};
        tick();
        bus.req_valid = 2'b00;
        repeat (5) tick();
        #1;
        check_eq("t4_hol_valid", 32'(bus.rsp_valid), 32'b01);
        check_eq("t4_hol_held", 32'(sb.size()), 32'd3);
        bus.rsp_ready = 2'b11;
        repeat (6) tick();
        check_eq("t4_drained", 32'(sb.size()), 32'd0);

        // Reset while a read is in flight: the tag is dropped, credit restored.
        bus.rsp_ready = 2'b01;
        bus.req_valid = 2'b01;
        bus.req_addr  = {8'd0, 8'd50};
        tick();
        bus.req_valid = 2'b00;
        areset = 1'b1;
        sb.delete();
        #1;
        check_eq("t5_rst_enq", 32'(bus.ram_enq), 32'd0);
        check_eq("t5_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b11;
        bus.req_addr  = {8'd61, 8'd60};
        #1;
        check_eq("t5_first_grant", 32'(bus.req_ready), 32'b01);
        phase_grants = 0;
        repeat (8) tick();
        check_eq("t5_credit", 32'(phase_grants), 32'(FIFO_DEPTH));
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (10) tick();
        check_eq("t5_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
